mul_div_controller: RTL

//  Sequences the MIPS multiply/divide datapath and owns the HI/LO register pair.
//  - Accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO from the EX stage.
//  - Runs a 1-cycle registered multiply and a 32-iteration restoring divider.
//  - Stalls EX for HI/LO access while an operation is in flight; supports cancel on exception flush.

---
 rtl/cpu_core_params_pkg.sv | 8 +
 rtl/mul_div_controller_pkg.sv | 26 ++
 rtl/mul_div_controller_divider.sv | 71 +++++++
 rtl/mul_div_controller.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/cpu_core_params_pkg.sv
// Core-wide data types shared by the CPU pipeline blocks.
package cpu_core_params;

    localparam int unsigned CPU_DATA_WIDTH = 32;

    typedef logic [CPU_DATA_WIDTH-1:0] cpu_data_t;

endpackage

// File: rtl/mul_div_controller_pkg.sv
// Types for the multiply/divide controller: FSM state, issue request and HI/LO pair.
package mul_div_params;

    import cpu_core_params::*;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } mul_div_state_t;

    typedef struct packed {
        logic      multiply;
        logic      divide;
        logic      signed_op;
        cpu_data_t source1;
        cpu_data_t source2;
    } mul_div_request_t;

    typedef struct packed {
        cpu_data_t high;
        cpu_data_t low;
    } high_low_t;

endpackage

// File: rtl/mul_div_controller_divider.sv
// Iterative restoring divider on unsigned magnitudes; one quotient bit per cycle.
module mul_div_divider
    import mul_div_params::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DIV_CYCLES = DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  cancel,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);

    localparam int unsigned COUNT_WIDTH = $clog2(DIV_CYCLES + 1);
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(DIV_CYCLES - 1);

    logic [DATA_WIDTH-1:0]  quotient_q;
    logic [DATA_WIDTH-1:0]  remainder_q;
    logic [DATA_WIDTH-1:0]  divisor_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   running_q;

    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] difference;
    logic                fits;

    // Quotient register doubles as the dividend shift source; its MSB feeds the remainder.
    always_comb begin
        shifted    = {remainder_q, quotient_q[DATA_WIDTH-1]};
        difference = shifted - {1'b0, divisor_q};
        fits       = ~difference[DATA_WIDTH];
    end

    assign done      = running_q & (count_q == LAST_COUNT);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            quotient_q  <= '0;
            remainder_q <= '0;
            divisor_q   <= '0;
            count_q     <= '0;
            running_q   <= 1'b0;
        end else if (cancel) begin
            count_q   <= '0;
            running_q <= 1'b0;
        end else if (start) begin
            quotient_q  <= dividend;
            remainder_q <= '0;
            divisor_q   <= divisor;
            count_q     <= '0;
            running_q   <= 1'b1;
        end else if (running_q) begin
            remainder_q <= fits ? difference[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
            quotient_q  <= {quotient_q[DATA_WIDTH-2:0], fits};
            if (count_q == LAST_COUNT) begin
                count_q   <= '0;
                running_q <= 1'b0;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_div_controller.sv
// MIPS multiply/divide sequencer: owns HI/LO, runs MULT/DIV, applies MTHI/MTLO, stalls EX.
module mul_div_controller
    import mul_div_params::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DIV_CYCLES = DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  op_valid,
    input  logic                  op_multiply,
    input  logic                  op_divide,
    input  logic                  op_signed,
    input  logic [DATA_WIDTH-1:0] source1,
    input  logic [DATA_WIDTH-1:0] source2,
    input  logic                  hl_write_valid,
    input  logic                  hl_write_high,
    input  logic [DATA_WIDTH-1:0] hl_write_data,
    input  logic                  read_high,
    input  logic                  read_low,
    input  logic                  flush,
    output logic                  stall,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] high_value,
    output logic [DATA_WIDTH-1:0] low_value
);

    mul_div_state_t   state;
    mul_div_request_t issue;
    high_low_t        hl;

    logic [DATA_WIDTH-1:0]   operand_a;
    logic [DATA_WIDTH-1:0]   operand_b;
    logic                    signed_q;

    logic                    accept;
    logic                    hl_apply;
    logic                    div_start;
    logic                    div_done;
    logic [DATA_WIDTH-1:0]   dividend_mag;
    logic [DATA_WIDTH-1:0]   divisor_mag;
    logic [DATA_WIDTH-1:0]   quotient;
    logic [DATA_WIDTH-1:0]   remainder;
    logic [2*DATA_WIDTH-1:0] ext_a;
    logic [2*DATA_WIDTH-1:0] ext_b;
    logic [2*DATA_WIDTH-1:0] product;
    logic                    quotient_neg;
    logic                    remainder_neg;

    assign issue = '{multiply:  op_multiply,
                     divide:    op_divide,
                     signed_op: op_signed,
                     source1:   source1,
                     source2:   source2};

    assign busy = (state != IDLE);
    // A simultaneous op and MTHI/MTLO in IDLE: the op is taken, the write must be retried.
    assign stall = busy ? (op_valid | hl_write_valid | read_high | read_low)
                        : (op_valid & hl_write_valid);

    assign accept    = ~busy & op_valid & ~flush & (issue.multiply | issue.divide);
    assign hl_apply  = ~busy & hl_write_valid & ~op_valid & ~flush;
    assign div_start = accept & issue.divide;

    always_comb begin
        dividend_mag = (issue.signed_op && issue.source1[DATA_WIDTH-1]) ? -issue.source1
                                                                        : issue.source1;
        divisor_mag  = (issue.signed_op && issue.source2[DATA_WIDTH-1]) ? -issue.source2
                                                                        : issue.source2;
    end

    // Sign-extend to full width; the truncated product is then exact for both signednesses.
    always_comb begin
        ext_a   = {{DATA_WIDTH{signed_q & operand_a[DATA_WIDTH-1]}}, operand_a};
        ext_b   = {{DATA_WIDTH{signed_q & operand_b[DATA_WIDTH-1]}}, operand_b};
        product = ext_a * ext_b;
    end

    assign quotient_neg  = signed_q & (operand_a[DATA_WIDTH-1] ^ operand_b[DATA_WIDTH-1]);
    assign remainder_neg = signed_q & operand_a[DATA_WIDTH-1];

    mul_div_divider #(
        .DATA_WIDTH(DATA_WIDTH),
        .DIV_CYCLES(DIV_CYCLES)
    ) u_divider (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (div_start),
        .cancel   (flush),
        .dividend (dividend_mag),
        .divisor  (divisor_mag),
        .done     (div_done),
        .quotient (quotient),
        .remainder(remainder)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            hl        <= '0;
            operand_a <= '0;
            operand_b <= '0;
            signed_q  <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hl_apply) begin
                        if (hl_write_high) begin
                            hl.high <= hl_write_data;
                        end else begin
                            hl.low <= hl_write_data;
                        end
                    end
                    if (accept) begin
                        operand_a <= issue.source1;
                        operand_b <= issue.source2;
                        signed_q  <= issue.signed_op;
                        state     <= issue.multiply ? MUL : DIV;
                    end
                end
                MUL: begin
                    hl.high <= product[2*DATA_WIDTH-1:DATA_WIDTH];
                    hl.low  <= product[DATA_WIDTH-1:0];
                    state   <= IDLE;
                end
                DIV: begin
                    if (div_done) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    hl.low  <= quotient_neg ? -quotient : quotient;
                    hl.high <= remainder_neg ? -remainder : remainder;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign high_value = hl.high;
    assign low_value  = hl.low;

endmodule
